// File: rtl/snn_phase_sequencer.sv
// Batch / image / time-unit sequencer for the SNN output stage; handshakes with the core and post_core.
// Optional decision timeout is compiled in when SNN_SEQ_TIMEOUT_EN is defined.

module snn_phase_sequencer #(
  parameter int unsigned T_STEPS     = 350,
  parameter int unsigned TU_W        = 10,
  parameter int unsigned IMG_W       = 16,
  parameter int unsigned DEC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [IMG_W-1:0] num_images,
  input  logic             core_step_done,
  input  logic             valid_deciding,
  input  logic [7:0]       image_label,
  output logic [1:0]       train_test_classify,
  output logic             coring,
  output logic             step_req,
  output logic             TU_incre,
  output logic             done_core_img,
  output logic             deciding,
  output logic [IMG_W-1:0] img_idx,
  output logic [TU_W-1:0]  tu_cnt,
  output logic [7:0]       label_out,
  output logic             label_valid,
  output logic             busy,
  output logic             done,
  output logic             err_timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StStep,
    StWait,
    StTick,
    StDecide,
    StNext,
    StFin
  } state_e;

  localparam logic [1:0] ModeClassify = 2'b11;

  // An out-of-range configuration never accepts a start, so it can never overrun tu_cnt.
  localparam bit CfgOk = (T_STEPS >= 1) && (T_STEPS < (1 << TU_W)) && (DEC_TIMEOUT >= 1);
  localparam logic [TU_W-1:0] TuLast = TU_W'(T_STEPS - 1);

  state_e state_q, state_d;

  logic [1:0]       mode_q, mode_d;
  logic [IMG_W-1:0] num_q, num_d;
  logic [IMG_W-1:0] img_q, img_d;
  logic [TU_W-1:0]  tu_q, tu_d;
  logic [7:0]       label_q, label_d;
  logic             label_valid_q, label_valid_d;
  logic             busy_q, busy_d;

  logic accept;
  logic last_tu;
  logic last_img;
  logic decide_hit;
  logic timeout_hit;

  assign accept     = (state_q == StIdle) && start && (mode != 2'b00) && CfgOk;
  assign last_tu    = (tu_q == TuLast);
  assign last_img   = (img_q == num_q - IMG_W'(1));
  assign decide_hit = (state_q == StDecide) && valid_deciding;

`ifdef SNN_SEQ_TIMEOUT_EN
  localparam int unsigned DecW = $clog2(DEC_TIMEOUT + 1);

  logic [DecW-1:0] dec_cnt_q, dec_cnt_d;
  logic            err_q, err_d;

  // The last DECIDE cycle is the one that sees a count of 1; a late valid_deciding still wins.
  assign timeout_hit = (state_q == StDecide) && !valid_deciding && (dec_cnt_q <= DecW'(1));
  assign err_timeout = err_q;

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    err_d     = err_q;
    if (accept) begin
      err_d = 1'b0;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end
    if (state_q == StTick) begin
      dec_cnt_d = DecW'(DEC_TIMEOUT);
    end else if ((state_q == StDecide) && (dec_cnt_q != '0)) begin
      dec_cnt_d = dec_cnt_q - DecW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      err_q     <= err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (num_images == '0) ? StFin : StStep;
        end
      end
      StStep: state_d = StWait;
      StWait: begin
        if (core_step_done) begin
          state_d = StTick;
        end
      end
      StTick: state_d = last_tu ? StDecide : StStep;
      StDecide: begin
        if (valid_deciding || timeout_hit) begin
          state_d = StNext;
        end
      end
      StNext: state_d = last_img ? StFin : StStep;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Decoded control outputs
  always_comb begin
    step_req      = 1'b0;
    TU_incre      = 1'b0;
    done_core_img = 1'b0;
    coring        = 1'b0;
    deciding      = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      StStep: begin
        step_req = 1'b1;
        coring   = 1'b1;
      end
      StWait: coring = 1'b1;
      StTick: begin
        coring        = 1'b1;
        TU_incre      = 1'b1;
        done_core_img = last_tu;
      end
      StDecide: deciding = 1'b1;
      StFin:    done     = 1'b1;
      default: ;
    endcase
  end

  // Batch, image and time-unit bookkeeping
  always_comb begin
    mode_d        = mode_q;
    num_d         = num_q;
    img_d         = img_q;
    tu_d          = tu_q;
    label_d       = label_q;
    label_valid_d = 1'b0;
    busy_d        = busy_q;

    if (accept) begin
      mode_d = mode;
      num_d  = num_images;
      img_d  = '0;
      tu_d   = '0;
      busy_d = 1'b1;
    end

    if (state_q == StTick) begin
      tu_d = last_tu ? '0 : tu_q + TU_W'(1);
    end

    if (decide_hit && (mode_q == ModeClassify)) begin
      label_d       = image_label;
      label_valid_d = 1'b1;
    end

    if ((state_q == StNext) && !last_img) begin
      img_d = img_q + IMG_W'(1);
    end

    if (state_q == StFin) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= 2'b00;
      num_q         <= '0;
      img_q         <= '0;
      tu_q          <= '0;
      label_q       <= '0;
      label_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      num_q         <= num_d;
      img_q         <= img_d;
      tu_q          <= tu_d;
      label_q       <= label_d;
      label_valid_q <= label_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign train_test_classify = mode_q;
  assign img_idx             = img_q;
  assign tu_cnt              = tu_q;
  assign label_out           = label_q;
  assign label_valid         = label_valid_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_snn_phase_sequencer.sv
// Randomized bench for snn_phase_sequencer: a procedural batch model predicts every output each cycle.
// Define SNN_SEQ_TIMEOUT_EN for both files to also exercise the decision timeout.

module tb_snn_phase_sequencer;

  localparam int unsigned T   = 4;
  localparam int unsigned TUW = 10;
  localparam int unsigned IW  = 16;
  localparam int unsigned DT  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [IW-1:0] num_images;
  logic          csd;
  logic          vd;
  logic [7:0]    image_label;

  logic [1:0]     ttc;
  logic           coring, step_req, tu_incre, done_core_img, deciding;
  logic [IW-1:0]  img_idx;
  logic [TUW-1:0] tu_cnt;
  logic [7:0]     label_out;
  logic           label_valid, busy, done, err_timeout;

  snn_phase_sequencer #(
    .T_STEPS    (T),
    .TU_W       (TUW),
    .IMG_W      (IW),
    .DEC_TIMEOUT(DT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .mode               (mode),
    .num_images         (num_images),
    .core_step_done     (csd),
    .valid_deciding     (vd),
    .image_label        (image_label),
    .train_test_classify(ttc),
    .coring             (coring),
    .step_req           (step_req),
    .TU_incre           (tu_incre),
    .done_core_img      (done_core_img),
    .deciding           (deciding),
    .img_idx            (img_idx),
    .tu_cnt             (tu_cnt),
    .label_out          (label_out),
    .label_valid        (label_valid),
    .busy               (busy),
    .done               (done),
    .err_timeout        (err_timeout)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle
  logic [1:0]     e_ttc;
  logic           e_coring, e_step, e_tui, e_dci, e_dec, e_lv, e_busy, e_done, e_err;
  logic [IW-1:0]  e_img;
  logic [TUW-1:0] e_tu;
  logic [7:0]     e_label;
  bit             chk_en = 1'b0;

  // Model of the sequencer's visible registers
  logic [1:0]     m_ttc;
  logic [IW-1:0]  m_img;
  logic [TUW-1:0] m_tu;
  logic [7:0]     m_label;
  logic           m_err;

  // Single extra literal check handed to the compare process
  bit    pin_valid = 1'b0;
  string pin_name = "";
  int    pin_act = 0;
  int    pin_exp = 0;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int n_tui = 0, n_dci = 0, n_lv = 0, n_step = 0, n_coring = 0, n_done = 0, n_bad_frame = 0;
  int done_cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tu_incre === 1'b1) n_tui++;
    if (done_core_img === 1'b1) n_dci++;
    if (label_valid === 1'b1) n_lv++;
    if (step_req === 1'b1) n_step++;
    if (coring === 1'b1) n_coring++;
    if ((tu_incre === 1'b1) && (coring !== 1'b1)) n_bad_frame++;
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("train_test_classify", 32'(ttc), 32'(e_ttc));
      chk("coring", 32'(coring), 32'(e_coring));
      chk("step_req", 32'(step_req), 32'(e_step));
      chk("TU_incre", 32'(tu_incre), 32'(e_tui));
      chk("done_core_img", 32'(done_core_img), 32'(e_dci));
      chk("deciding", 32'(deciding), 32'(e_dec));
      chk("img_idx", 32'(img_idx), 32'(e_img));
      chk("tu_cnt", 32'(tu_cnt), 32'(e_tu));
      chk("label_out", 32'(label_out), 32'(e_label));
      chk("label_valid", 32'(label_valid), 32'(e_lv));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err_timeout", 32'(err_timeout), 32'(e_err));
      if (pin_valid) chk(pin_name, 32'(pin_act), 32'(pin_exp));
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_base(input logic b);
    e_busy   = b;
    e_coring = 1'b0;
    e_step   = 1'b0;
    e_tui    = 1'b0;
    e_dci    = 1'b0;
    e_dec    = 1'b0;
    e_lv     = 1'b0;
    e_done   = 1'b0;
    e_ttc    = m_ttc;
    e_img    = m_img;
    e_tu     = m_tu;
    e_label  = m_label;
    e_err    = m_err;
  endtask

  task automatic clean();
    start       = 1'b0;
    mode        = 2'b00;
    num_images  = '0;
    csd         = 1'b0;
    vd          = 1'b0;
    image_label = 8'h00;
  endtask

  // Inputs that the sequencer must ignore in the current cycle
  task automatic noise();
    start       = 1'($urandom);
    mode        = 2'($urandom);
    num_images  = IW'($urandom);
    csd         = 1'($urandom);
    vd          = 1'($urandom);
    image_label = 8'($urandom);
  endtask

  task automatic model_reset();
    m_ttc   = 2'b00;
    m_img   = '0;
    m_tu    = '0;
    m_label = 8'h00;
    m_err   = 1'b0;
  endtask

  task automatic pin(input string nm, input int act, input int exp_v);
    clean();
    exp_base(1'b0);
    pin_name  = nm;
    pin_act   = act;
    pin_exp   = exp_v;
    pin_valid = 1'b1;
    next_cyc();
    pin_valid = 1'b0;
  endtask

  // One batch: n images of T time units each; negative delay/label arguments mean random.
  task automatic run_batch(input logic [1:0] md, input int n, input int csd_dly, input int vd_dly,
                           input int lbl, input int rst_img, input int rst_tu);
    int         d;
    logic [7:0] lab;
    bit         got;
    clean();
    exp_base(1'b0);
    start      = 1'b1;
    mode       = md;
    num_images = IW'(n);
    start_cyc  = cyc;
    next_cyc();
    m_ttc = md;
    m_img = '0;
    m_tu  = '0;
    m_err = 1'b0;
    for (int img = 0; img < n; img++) begin
      for (int tu = 0; tu < int'(T); tu++) begin
        noise();
        exp_base(1'b1);
        e_step   = 1'b1;
        e_coring = 1'b1;
        next_cyc();
        if ((img == rst_img) && (tu == rst_tu)) begin
          noise();
          csd = 1'b0;
          rst = 1'b1;
          exp_base(1'b1);
          e_coring = 1'b1;
          next_cyc();
          rst = 1'b0;
          clean();
          model_reset();
          exp_base(1'b0);
          next_cyc();
          return;
        end
        d = (csd_dly < 0) ? int'($urandom_range(0, 3)) : csd_dly;
        for (int k = 0; k < d; k++) begin
          noise();
          csd = 1'b0;
          exp_base(1'b1);
          e_coring = 1'b1;
          next_cyc();
        end
        noise();
        csd = 1'b1;
        exp_base(1'b1);
        e_coring = 1'b1;
        next_cyc();
        noise();
        exp_base(1'b1);
        e_coring = 1'b1;
        e_tui    = 1'b1;
        e_dci    = (tu == int'(T) - 1);
        next_cyc();
        m_tu = (tu == int'(T) - 1) ? '0 : TUW'(tu + 1);
      end
      d   = (vd_dly < 0) ? int'($urandom_range(0, 5)) : vd_dly;
      got = 1'b1;
`ifdef SNN_SEQ_TIMEOUT_EN
      if (d >= int'(DT)) begin
        got = 1'b0;
        d   = int'(DT);
      end
`endif
      for (int k = 0; k < d; k++) begin
        noise();
        vd = 1'b0;
        exp_base(1'b1);
        e_dec = 1'b1;
        next_cyc();
      end
      lab = (lbl < 0) ? 8'($urandom) : 8'(lbl);
      if (got) begin
        noise();
        vd          = 1'b1;
        image_label = lab;
        exp_base(1'b1);
        e_dec = 1'b1;
        next_cyc();
      end
      if (got && (m_ttc == 2'b11)) m_label = lab;
      if (!got) m_err = 1'b1;
      noise();
      exp_base(1'b1);
      e_lv = got && (m_ttc == 2'b11);
      next_cyc();
      if (img < n - 1) m_img = m_img + IW'(1);
    end
    noise();
    exp_base(1'b1);
    e_done = 1'b1;
    next_cyc();
    clean();
    exp_base(1'b0);
    next_cyc();
  endtask

  initial begin
    int s_tui, s_dci, s_lv, s_step, s_coring, s_done;
    rst = 1'b1;
    clean();
    model_reset();
    exp_base(1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    next_cyc();
    rst = 1'b0;
    next_cyc();

    // Classify, two images, fixed handshake delays
    s_tui = n_tui; s_dci = n_dci; s_lv = n_lv; s_done = n_done;
    run_batch(2'b11, 2, 0, 3, 8'h07, -1, -1);
    pin("t1_tu_incre_count", n_tui - s_tui, 8);
    pin("t1_done_core_img_count", n_dci - s_dci, 2);
    pin("t1_label_valid_count", n_lv - s_lv, 2);
    pin("t1_label_out", int'(label_out), 7);
    pin("t1_done_count", n_done - s_done, 1);

    // Train, one image: no label pulses, every TU_incre framed by coring
    s_tui = n_tui; s_lv = n_lv; s_done = n_done;
    run_batch(2'b01, 1, -1, -1, -1, -1, -1);
    pin("t2_tu_incre_count", n_tui - s_tui, 4);
    pin("t2_label_valid_count", n_lv - s_lv, 0);
    pin("t2_done_count", n_done - s_done, 1);
    pin("t2_unframed_tu_incre", n_bad_frame, 0);

    // Illegal mode start is ignored
    s_step = n_step;
    clean();
    exp_base(1'b0);
    start      = 1'b1;
    mode       = 2'b00;
    num_images = IW'(3);
    next_cyc();
    clean();
    exp_base(1'b0);
    next_cyc();
    pin("t3_step_req_count", n_step - s_step, 0);

    // Empty batch: straight to done, no core activity
    s_step = n_step; s_coring = n_coring; s_done = n_done;
    run_batch(2'b10, 0, -1, -1, -1, -1, -1);
    pin("t4_step_req_count", n_step - s_step, 0);
    pin("t4_coring_count", n_coring - s_coring, 0);
    pin("t4_done_count", n_done - s_done, 1);
    pin("t4_done_cycle_inclusive", done_cyc - start_cyc + 1, 2);

    // Reset during WAIT of image 1 at tu 2, then a fresh batch restarts from zero
    s_done = n_done;
    run_batch(2'b11, 2, -1, -1, -1, 1, 2);
    pin("t5_no_done_on_reset", n_done - s_done, 0);
    run_batch(2'b01, 1, -1, -1, -1, -1, -1);

`ifdef SNN_SEQ_TIMEOUT_EN
    s_lv = n_lv; s_done = n_done;
    run_batch(2'b11, 2, 0, 1000, -1, -1, -1);
    pin("t6_err_timeout", int'(err_timeout), 1);
    pin("t6_label_valid_count", n_lv - s_lv, 0);
    pin("t6_done_count", n_done - s_done, 1);
    run_batch(2'b10, 1, -1, -1, -1, -1, -1);
`endif

    for (int i = 0; i < 12; i++) begin
      run_batch(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), -1, -1, -1, -1, -1);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snn_phase_sequencer.md
Name: snn_phase_sequencer

Overview:
- Top-level sequencer for the SNN output stage.
- Drives image presentation and time-unit stepping of the neuron core, and asserts the coring/TU_incre/done_core_img/deciding controls consumed by post_core.
- Waits for post_core's valid_deciding, then returns the classified label.
- Runs a batch of images in train, test or classify mode from a single start pulse.

Parameters:
- T_STEPS, 350: time units per image; legal range 1..2^TU_W-1.
- TU_W, 10: width of the time-unit counter.
- IMG_W, 16: width of the image counter and num_images.
- DEC_TIMEOUT, 64: cycles to wait for valid_deciding. Used only with SNN_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle batch start request
- mode  in  2  01 train, 10 test, 11 classify, 00 illegal
- num_images  in  IMG_W  images in the batch
- core_step_done  in  1  core has finished one time-unit update
- valid_deciding  in  1  post_core decision complete
- image_label  in  8  post_core classification result
- train_test_classify  out  2  latched mode, to post_core
- coring  out  1  image in progress, to post_core
- step_req  out  1  one-cycle request for the core to compute one time unit
- TU_incre  out  1  one-cycle time-unit strobe
- done_core_img  out  1  one-cycle, coincident with the final TU_incre of an image
- deciding  out  1  high while awaiting valid_deciding
- img_idx  out  IMG_W  current image index
- tu_cnt  out  TU_W  current time unit
- label_out  out  8  captured classify label
- label_valid  out  1  one-cycle pulse when label_out updates
- busy  out  1  batch active
- done  out  1  one-cycle batch-complete pulse
- err_timeout  out  1  sticky decision timeout flag

Behaviour:
- Reset (synchronous): every output is 0, the FSM is in IDLE and all counters are 0. rst asserted mid-batch returns to IDLE at the next edge. No done pulse is issued.
- FSM states: IDLE, STEP, WAIT, TICK, DECIDE, NEXT, FIN.
- IDLE:
  - start with mode != 00 latches mode into train_test_classify and num_images into an internal register, clears img_idx, tu_cnt and err_timeout, and sets busy.
  - Goes to FIN if num_images == 0, else to STEP.
  - start with mode == 00 is ignored.
  - start while busy is ignored.
- STEP: step_req = 1 for one cycle, then WAIT. A core_step_done arriving in STEP is ignored.
- WAIT: hold until core_step_done = 1, then TICK.
- TICK:
  - TU_incre = 1 for one cycle.
  - If tu_cnt == T_STEPS-1: done_core_img = 1 in the same cycle, tu_cnt <= 0, next state DECIDE.
  - Otherwise tu_cnt increments and the next state is STEP.
- coring = 1 in STEP, WAIT and TICK; 0 elsewhere. It therefore frames every TU_incre.
- DECIDE:
  - deciding = 1 until valid_deciding = 1.
  - On valid_deciding in classify mode (11): label_out <= image_label and label_valid pulses that cycle+1, coincident with entry to NEXT.
  - Next state NEXT.
- NEXT:
  - If img_idx == num_images-1, go to FIN.
  - Otherwise img_idx increments and the next state is STEP.
- FIN: done = 1 for one cycle, busy <= 0, back to IDLE. img_idx holds its final value.
- valid_deciding outside DECIDE is ignored.
- Latency:
  - One time unit takes at least 3 cycles (STEP, WAIT with immediate core_step_done, TICK).
  - From start to the first step_req is 1 cycle.
- Arithmetic: all counters are unsigned. tu_cnt never exceeds T_STEPS-1. img_idx never wraps within a batch.

Optional Feature:
- SNN_SEQ_TIMEOUT_EN defined:
  - DECIDE runs a down-counter loaded with DEC_TIMEOUT on entry.
  - If it reaches 0 without valid_deciding: err_timeout <= 1 (sticky until the next accepted start), label_valid is not pulsed, and the FSM goes to NEXT.
- Not defined: DECIDE waits indefinitely and err_timeout is tied to 0.

Test Plan:
1. T_STEPS=4, mode=11, num_images=2, core_step_done 1 cycle after each step_req, valid_deciding 3 cycles after deciding, image_label=8'h07 -> 8 TU_incre pulses; done_core_img on the 4th and 8th; label_out=07 with label_valid twice; done 1 cycle after the second NEXT; busy drops.
2. mode=01, num_images=1, T_STEPS=4 -> 4 TU_incre, each with coring=1; deciding until valid_deciding; label_valid never pulses; done=1.
3. start with mode=00, and separately a start during an active batch -> no state change, busy unchanged, no step_req.
4. num_images=0, mode=10 -> no step_req and no coring; done pulses exactly 2 cycles after start.
5. rst held 1 cycle in WAIT of image 1, tu_cnt=2 -> next cycle all outputs 0 and IDLE; a subsequent start restarts at img_idx=0, tu_cnt=0.
6. With SNN_SEQ_TIMEOUT_EN and DEC_TIMEOUT=8, valid_deciding never asserted, num_images=2 -> err_timeout=1 after 8 cycles in DECIDE; image 2 proceeds; done pulses; err_timeout stays 1 until the next start.
